// File: rtl/proc_ctrl.sv
// proc_ctrl: pipeline control unit for the five-stage TinyRV1 datapath (F/D/X/M/W)
module proc_ctrl #(
  parameter bit RESET_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d2c_inst,
  input  logic        d2c_eq_X,
  output logic        c2d_imemreq_val_F,
  output logic        c2d_reg_en_F,
  output logic [1:0]  c2d_pc_sel_F,
  output logic        c2d_reg_en_D,
  output logic [1:0]  c2d_imm_type_D,
  output logic [1:0]  c2d_op1_byp_sel_D,
  output logic [1:0]  c2d_op2_byp_sel_D,
  output logic        c2d_op1_sel_D,
  output logic [1:0]  c2d_op2_sel_D,
  output logic        c2d_alu_fn_X,
  output logic        c2d_result_sel_X,
  output logic        c2d_dmemreq_val_M,
  output logic        c2d_dmemreq_type_M,
  output logic        c2d_wb_sel_M,
  output logic        c2d_rf_wen_W,
  output logic [4:0]  c2d_rf_waddr_W
);
  logic started;
  logic val_D, val_X, val_M, val_W;
  logic [4:0] rd_X, rd_M, rd_W;
  logic wen_X, wen_M, wen_W;
  logic is_lw_X, is_sw_X, is_mul_X, is_bne_X, is_lw_M, is_sw_M;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic is_add, is_mul, is_addi, is_lw, is_sw, is_jal, is_jr, is_bne;
  logic use1, use2, wen_D, ld_use, br, stall, jmp;

  assign op  = d2c_inst[6:0];
  assign rd  = d2c_inst[11:7];
  assign f3  = d2c_inst[14:12];
  assign rs1 = d2c_inst[19:15];
  assign rs2 = d2c_inst[24:20];
  assign f7  = d2c_inst[31:25];

  assign is_add  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h00;
  assign is_mul  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h01;
  assign is_addi = op == 7'h13 && f3 == 3'd0;
  assign is_lw   = op == 7'h03 && f3 == 3'd2;
  assign is_sw   = op == 7'h23 && f3 == 3'd2;
  assign is_jal  = op == 7'h6f;
  assign is_jr   = op == 7'h67 && f3 == 3'd0 && d2c_inst[31:20] == 12'd0;
  assign is_bne  = op == 7'h63 && f3 == 3'd1;

  assign use1  = val_D && (is_add || is_mul || is_addi || is_lw || is_sw || is_jr || is_bne);
  assign use2  = val_D && (is_add || is_mul || is_sw || is_bne);
  assign wen_D = (is_add || is_mul || is_addi || is_lw || is_jal) && rd != 5'd0;

  // a load in X cannot forward its data yet; a taken branch squashes D anyway, so it wins
  assign ld_use = val_X && is_lw_X && wen_X && ((use1 && rd_X == rs1) || (use2 && rd_X == rs2));
  assign br     = val_X && is_bne_X && !d2c_eq_X;
  assign stall  = ld_use && !br;
  assign jmp    = val_D && (is_jal || is_jr) && !stall && !br;

  assign c2d_imemreq_val_F = rst && (started || RESET_FETCH);
  assign c2d_reg_en_F      = !stall;
  assign c2d_reg_en_D      = !stall;
  assign c2d_pc_sel_F      = br ? 2'd3 : jmp ? (is_jal ? 2'd2 : 2'd1) : 2'd0;

  assign c2d_imm_type_D = !val_D ? 2'd0 : is_sw ? 2'd1 : is_jal ? 2'd2 : is_bne ? 2'd3 : 2'd0;
  assign c2d_op1_sel_D  = val_D && is_jal;
  assign c2d_op2_sel_D  = !val_D ? 2'd0 : (is_addi || is_lw || is_sw) ? 2'd1 : is_jal ? 2'd2 : 2'd0;

  // youngest writer wins; wen already excludes x0 so rs=0 always reads the RF
  assign c2d_op1_byp_sel_D = (!use1 || rs1 == 5'd0) ? 2'd0 :
                             (val_X && wen_X && rd_X == rs1) ? 2'd1 :
                             (val_M && wen_M && rd_M == rs1) ? 2'd2 :
                             (val_W && wen_W && rd_W == rs1) ? 2'd3 : 2'd0;
  assign c2d_op2_byp_sel_D = (!use2 || rs2 == 5'd0) ? 2'd0 :
                             (val_X && wen_X && rd_X == rs2) ? 2'd1 :
                             (val_M && wen_M && rd_M == rs2) ? 2'd2 :
                             (val_W && wen_W && rd_W == rs2) ? 2'd3 : 2'd0;

  assign c2d_alu_fn_X       = val_X && is_bne_X;
  assign c2d_result_sel_X   = val_X && is_mul_X;
  assign c2d_dmemreq_val_M  = val_M && (is_lw_M || is_sw_M);
  assign c2d_dmemreq_type_M = val_M && is_sw_M;
  assign c2d_wb_sel_M       = val_M && is_lw_M;
  assign c2d_rf_wen_W       = val_W && wen_W;
  assign c2d_rf_waddr_W     = c2d_rf_wen_W ? rd_W : 5'd0;

  // advance per-stage control state; stall holds D and bubbles X, redirects squash younger slots
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      started  <= 1'b0;
      val_D    <= 1'b0;
      val_X    <= 1'b0;
      val_M    <= 1'b0;
      val_W    <= 1'b0;
      rd_X     <= 5'd0;
      rd_M     <= 5'd0;
      rd_W     <= 5'd0;
      wen_X    <= 1'b0;
      wen_M    <= 1'b0;
      wen_W    <= 1'b0;
      is_lw_X  <= 1'b0;
      is_sw_X  <= 1'b0;
      is_mul_X <= 1'b0;
      is_bne_X <= 1'b0;
      is_lw_M  <= 1'b0;
      is_sw_M  <= 1'b0;
    end else begin
      started  <= 1'b1;
      if (!stall) val_D <= c2d_imemreq_val_F && !br && !jmp;
      val_X    <= val_D && !stall && !br;
      rd_X     <= rd;
      wen_X    <= wen_D;
      is_lw_X  <= is_lw;
      is_sw_X  <= is_sw;
      is_mul_X <= is_mul;
      is_bne_X <= is_bne;
      val_M    <= val_X;
      rd_M     <= rd_X;
      wen_M    <= wen_X;
      is_lw_M  <= is_lw_X;
      is_sw_M  <= is_sw_X;
      val_W    <= val_M;
      rd_W     <= rd_M;
      wen_W    <= wen_M;
    end
endmodule
